// File: rtl/uart_rx_async.sv
// Async UART receiver: 16x-oversampled, majority-of-three bit recovery, 2-entry RCREG FIFO with per-entry FERR.
// Latency: push on the stop bit's 10th tick (rcif one clk later); a full FIFO without a same-cycle pop drops the frame and sets sticky oerr.
module uart_rx_async (
    input  logic       clk,
    input  logic       rst,
    input  logic       spen,
    input  logic       cren,
    input  logic       rx9,
    input  logic       rx16_tick,
    input  logic       rx_pin,
    input  logic       rcreg_rd_en,
    output logic [7:0] rcreg_out,
    output logic       rx9d,
    output logic       ferr,
    output logic       rcif,
    output logic       oerr
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    typedef struct packed {
        logic       ferr;
        logic       rx9d;
        logic [7:0] dat;
    } entry_t;

    logic [1:0] sync_q;
    logic       rxs;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [8:0] shreg_q, shreg_d;
    logic       s7_q, s7_d, s8_q, s8_d, maj_q, maj_d;
    logic       frame9_q, frame9_d;
    logic       maj_live, run, push;
    entry_t     push_ent;

    entry_t     fifo_q [2];
    entry_t     head;
    logic [1:0] count_q, fill;
    logic       pop_eff, push_ok, overrun, wr_idx, oerr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_pin};
    end
    assign rxs = sync_q[1];

    assign run      = spen && cren && !oerr_q;
    assign maj_live = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            s7_q      <= 1'b0;
            s8_q      <= 1'b0;
            maj_q     <= 1'b0;
            frame9_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            maj_q     <= maj_d;
            frame9_q  <= frame9_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        maj_d     = maj_q;
        frame9_d  = frame9_q;
        push      = 1'b0;
        push_ent  = '0;
        if (!run) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
            shreg_d   = '0;
        end else if (rx16_tick) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) s7_d = rxs;
            if (cnt_q == 4'd8) s8_d = rxs;
            if (cnt_q == 4'd9) maj_d = maj_live;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d   = START;
                        cnt_d     = 4'd1;
                        bit_idx_d = '0;
                        shreg_d   = '0;
                        frame9_d  = rx9;
                    end
                end
                START: begin
                    if (cnt_q == 4'd15) begin
                        state_d   = maj_q ? IDLE : DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == 4'd15) begin
                        shreg_d[bit_idx_q] = maj_q;
                        if (bit_idx_q == (frame9_q ? 4'd8 : 4'd7)) state_d = STOP;
                        else bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
                STOP: begin
                    // Leave at sample 9 so a start edge in the stop-bit tail is not missed.
                    if (cnt_q == 4'd9) begin
                        push          = 1'b1;
                        push_ent.ferr = ~maj_live;
                        push_ent.rx9d = frame9_q & shreg_q[8];
                        push_ent.dat  = shreg_q[7:0];
                        state_d       = IDLE;
                        cnt_d         = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pop_eff = rcreg_rd_en && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_eff);
    assign overrun = push && (count_q == 2'd2) && !pop_eff;
    assign fill    = count_q - {1'b0, pop_eff};
    assign wr_idx  = (fill == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            oerr_q    <= 1'b0;
        end else if (!spen) begin
            count_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            oerr_q    <= 1'b0;
        end else begin
            if (pop_eff) fifo_q[0] <= fifo_q[1];
            if (push_ok) fifo_q[wr_idx] <= push_ent;
            count_q <= count_q - {1'b0, pop_eff} + {1'b0, push_ok};
            if (!cren)        oerr_q <= 1'b0;
            else if (overrun) oerr_q <= 1'b1;
        end
    end

    assign head      = (count_q != 2'd0) ? fifo_q[0] : '0;
    assign rcreg_out = head.dat;
    assign rx9d      = head.rx9d;
    assign ferr      = head.ferr;
    assign rcif      = (count_q != 2'd0);
    assign oerr      = oerr_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async: frames driven tick-aligned at a 16-tick bit period.
module tb_uart_rx_async;

    logic       clk = 1'b0;
    logic       rst;
    logic       spen, cren, rx9, rx16_tick, rx_pin, rcreg_rd_en;
    logic [7:0] rcreg_out;
    logic       rx9d, ferr, rcif, oerr;

    int total = 0;
    int bad   = 0;
    int tcnt  = 0;

    uart_rx_async dut (
        .clk         (clk),
        .rst         (rst),
        .spen        (spen),
        .cren        (cren),
        .rx9         (rx9),
        .rx16_tick   (rx16_tick),
        .rx_pin      (rx_pin),
        .rcreg_rd_en (rcreg_rd_en),
        .rcreg_out   (rcreg_out),
        .rx9d        (rx9d),
        .ferr        (ferr),
        .rcif        (rcif),
        .oerr        (oerr)
    );

    initial forever #5 clk = ~clk;

    // One tick every 4 clk, changed on the falling edge so it is stable across the rising edge.
    initial begin
        rx16_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            rx16_tick = (tcnt == 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (rx16_tick !== 1'b1);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rx_pin = v;
        repeat (n) wait_tick();
    endtask

    task automatic send_head(input logic [8:0] d, input int nbits, input bit glitch);
        drive(1'b1, 1);
        drive(1'b0, 16);
        for (int i = 0; i < nbits; i++) begin
            if (glitch) begin
                drive(d[i], 8);
                drive(~d[i], 1);
                drive(d[i], 7);
            end else begin
                drive(d[i], 16);
            end
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input logic stop_v);
        send_head(d, nbits, 1'b0);
        drive(stop_v, 16);
        drive(1'b1, 20);
    endtask

    task automatic pop();
        rcreg_rd_en = 1'b1;
        @(posedge clk);
        #1 rcreg_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; spen = 1'b0; cren = 1'b0; rx9 = 1'b0;
        rx_pin = 1'b1; rcreg_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rcreg", {8'h0, rcreg_out}, 16'h0000);
        check("reset_rx9d",  {15'h0, rx9d},     16'h0000);
        check("reset_ferr",  {15'h0, ferr},     16'h0000);
        check("reset_rcif",  {15'h0, rcif},     16'h0000);
        check("reset_oerr",  {15'h0, oerr},     16'h0000);
        rst = 1'b0;
        spen = 1'b1; cren = 1'b1;
        drive(1'b1, 4);

        // Basic 8-bit frame with push-edge timing
        send_head(9'h0A5, 8, 1'b0);
        drive(1'b1, 9);
        check("a5_rcif_before_push", {15'h0, rcif}, 16'h0000);
        drive(1'b1, 1);
        check("a5_rcif_at_push", {15'h0, rcif}, 16'h0001);
        drive(1'b1, 26);
        check("a5_data", {8'h0, rcreg_out}, 16'h00A5);
        check("a5_ferr", {15'h0, ferr},     16'h0000);
        check("a5_rx9d", {15'h0, rx9d},     16'h0000);
        pop();
        check("a5_rcif_after_pop", {15'h0, rcif},      16'h0000);
        check("a5_empty_data",     {8'h0, rcreg_out},  16'h0000);

        // False start then a real frame
        drive(1'b1, 1);
        drive(1'b0, 5);
        drive(1'b1, 24);
        check("false_start_rcif", {15'h0, rcif}, 16'h0000);
        send_frame(9'h03C, 8, 1'b1);
        check("3c_data", {8'h0, rcreg_out}, 16'h003C);
        check("3c_ferr", {15'h0, ferr},     16'h0000);
        pop();

        // Glitch on sample 8 of every data bit; stop bit low
        send_head(9'h000, 8, 1'b1);
        drive(1'b0, 16);
        drive(1'b1, 24);
        check("glitch_rcif", {15'h0, rcif},     16'h0001);
        check("glitch_data", {8'h0, rcreg_out}, 16'h0000);
        check("glitch_ferr", {15'h0, ferr},     16'h0001);
        pop();
        check("glitch_single_entry", {15'h0, rcif}, 16'h0000);

        // 9-bit frame
        rx9 = 1'b1;
        send_frame(9'h155, 9, 1'b1);
        rx9 = 1'b0;
        check("nine_data", {8'h0, rcreg_out}, 16'h0055);
        check("nine_rx9d", {15'h0, rx9d},     16'h0001);
        check("nine_ferr", {15'h0, ferr},     16'h0000);
        pop();

        // Overrun
        send_frame(9'h011, 8, 1'b1);
        send_frame(9'h022, 8, 1'b1);
        send_frame(9'h033, 8, 1'b1);
        check("ovr_oerr", {15'h0, oerr},     16'h0001);
        check("ovr_head", {8'h0, rcreg_out}, 16'h0011);
        pop();
        check("ovr_second", {8'h0, rcreg_out}, 16'h0022);
        check("ovr_rcif2",  {15'h0, rcif},     16'h0001);
        pop();
        check("ovr_33_lost", {15'h0, rcif}, 16'h0000);
        check("ovr_sticky",  {15'h0, oerr}, 16'h0001);
        send_frame(9'h066, 8, 1'b1);
        check("ovr_ignored", {15'h0, rcif}, 16'h0000);
        cren = 1'b0;
        @(posedge clk);
        #1 cren = 1'b1;
        check("ovr_cleared", {15'h0, oerr}, 16'h0000);
        send_frame(9'h044, 8, 1'b1);
        check("ovr_recover_data", {8'h0, rcreg_out}, 16'h0044);
        check("ovr_recover_oerr", {15'h0, oerr},     16'h0000);
        pop();

        // Full FIFO with pop on the push cycle
        send_frame(9'h011, 8, 1'b1);
        send_frame(9'h022, 8, 1'b1);
        check("full_head", {8'h0, rcreg_out}, 16'h0011);
        send_head(9'h033, 8, 1'b0);
        drive(1'b1, 9);
        repeat (3) @(posedge clk);
        #1 rcreg_rd_en = 1'b1;
        wait_tick();
        rcreg_rd_en = 1'b0;
        drive(1'b1, 26);
        check("simul_oerr", {15'h0, oerr},     16'h0000);
        check("simul_head", {8'h0, rcreg_out}, 16'h0022);
        pop();
        check("simul_tail", {8'h0, rcreg_out}, 16'h0033);
        pop();
        check("simul_empty", {15'h0, rcif}, 16'h0000);

        // cren drop mid-frame
        drive(1'b1, 1);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b1, 8);
        cren = 1'b0;
        drive(1'b0, 16 * 5 + 8);
        drive(1'b1, 36);
        cren = 1'b1;
        check("cren_drop_rcif", {15'h0, rcif}, 16'h0000);
        check("cren_drop_oerr", {15'h0, oerr}, 16'h0000);
        send_frame(9'h081, 8, 1'b1);
        check("after_drop_data", {8'h0, rcreg_out}, 16'h0081);

        // spen low flushes the FIFO
        spen = 1'b0;
        @(posedge clk);
        #1 spen = 1'b1;
        check("spen_flush_rcif", {15'h0, rcif},     16'h0000);
        check("spen_flush_data", {8'h0, rcreg_out}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
